hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
// - Pipeline hazard controller for the 5-stage RV32I core; drives the flush/enable inputs of the IF/ID and ID/EX registers.
// - Detects load-use hazards (stall + bubble), applies control-hazard flushes on a taken branch/jump resolved in EX,
//   and generates EX-stage operand forwarding selects.
// - Keeps a shadow scoreboard of the EX/MEM/WB destinations that tracks the ID/EX, EX/MEM and MEM/WB registers
//   cycle-for-cycle. Provides saturating stall/flush performance counters.
// PARAMETERS
// - CNT_W  32  width of the stall_cnt / flush_cnt performance counters
// PORTS
// - clk          in   1      core clock; all state updates on posedge
// - rst          in   1      synchronous, active-high reset
// - INST_ID      in   32     instruction currently in ID (IF/ID output)
// - PCSel_EX     in   1      taken branch or jump resolved in EX this cycle
// - PC_en        out  1      PC register load enable
// - IF_ID_en     out  1      IF/ID register load enable
// - IF_ID_flush  out  1      IF/ID register loads a NOP (0x00000013)
// - ID_EX_flush  out  1      ID/EX register loads a bubble
// - FwdA         out  2      EX rs1 source: 00 regfile, 01 MEM ALU result, 10 WB data
// - FwdB         out  2      EX rs2 source: same encoding as FwdA
// - stall_cnt    out  CNT_W  count of load-use stall cycles, saturating
// - flush_cnt    out  CNT_W  count of branch-flush cycles, saturating
// BEHAVIOUR
// - ID decode from INST_ID opcode [6:0]:
//   - rs1 used: all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111.
//   - rs2 used: R 0110011, S 0100011, B 1100011.
//   - Writes rd: all opcodes except S, B, FENCE 0001111, SYSTEM 1110011. rd = x0 counts as no write.
//   - is_load: opcode 0000011.
// - Scoreboard: per stage EX/MEM/WB, entries {valid, rd[4:0], is_load}. EX also holds rs1/rs2 with their used bits.
//   - Every cycle: WB <= MEM, MEM <= EX.
//   - EX <= ID decode fields, or an invalid entry when ID_EX_flush = 1.
//   - No freeze state: the ID/EX register has no hold input.
// - Load-use hazard (lu): EX.valid, EX.is_load, EX.rd != 0, and (rs1 used and INST_ID[19:15] == EX.rd,
//   or rs2 used and INST_ID[24:20] == EX.rd).
//   - Response: PC_en = 0, IF_ID_en = 0, ID_EX_flush = 1 for one cycle.
//   - Next cycle the load is in MEM and the consumer is still in ID, so no second stall; the value is forwarded from WB.
// - Branch flush: PCSel_EX = 1 -> IF_ID_flush = 1, ID_EX_flush = 1, PC_en = 1, IF_ID_en = 1. Two-cycle penalty.
// - Branch and lu in the same cycle: the branch wins. The lu stall is suppressed and stall_cnt does not increment.
// - Idle cycle: PC_en = 1, IF_ID_en = 1, both flushes = 0.
// - Control outputs are combinational from INST_ID, PCSel_EX and registered scoreboard state. Zero-cycle latency.
// - Forwarding, for operand rs1 of the EX entry (FwdB identical with rs2):
//   - MEM.valid, MEM.rd != 0, rs used, MEM.rd == rs -> 01.
//   - Else WB.valid, WB.rd != 0, rs used, WB.rd == rs -> 10.
//   - Else 00. MEM has priority over WB.
//   - The EX entry never forwards from MEM when MEM.is_load; the lu stall guarantees this case cannot occur.
// - Register file is write-through; no ID-stage forwarding is generated here.
// - Counters: stall_cnt += 1 on each applied lu cycle; flush_cnt += 1 on each PCSel_EX cycle.
//   Both saturate at 2^CNT_W - 1 with no wrap.
// - Reset: while rst = 1, PC_en = 1, IF_ID_en = 1, IF_ID_flush = 0, ID_EX_flush = 0, FwdA = 00, FwdB = 00.
//   All scoreboard entries invalid; both counters = 0.
//   Reset asserted mid-operation discards all in-flight entries on the next edge.
// TESTING
// - lw x5,0(x1) then add x6,x5,x2 -> one cycle PC_en = 0, IF_ID_en = 0, ID_EX_flush = 1; then add in EX with FwdA = 10; stall_cnt = 1.
// - add x3,x1,x2; add x3,x3,x3; sub x4,x3,x3 -> sub in EX has FwdA = FwdB = 01 (MEM has priority over the older WB x3).
// - lw x0,0(x1) then add x6,x0,x0 -> no stall, FwdA = FwdB = 00.
// - PCSel_EX = 1 for one cycle while ID holds a load-use consumer -> IF_ID_flush = 1, ID_EX_flush = 1, PC_en = 1; flush_cnt = 1, stall_cnt = 0.
// - sw x5,0(x1) in ID behind lw x5 -> stall (rs2 used); beq x0,x0 behind lw x5 -> no stall; lui x5 behind lw x5 -> no stall.
// - CNT_W = 4, 20 consecutive branch flushes -> flush_cnt holds 15.
//   rst pulsed with a load in EX -> scoreboard cleared; next ID consumer of that rd is not stalled.

Source files
------------

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and EX forwarding control for a 5-stage RV32I pipeline.
// Latency: control and forwarding outputs are combinational (same cycle); scoreboard advances every edge.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and injects an ID/EX bubble.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      INST_ID,
  input  logic             PCSel_EX,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // ID decode
  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_wr, id_ld;

  // Shadow scoreboard: EX tracks ID/EX, MEM tracks EX/MEM, WB tracks MEM/WB
  logic       ex_vld_q, ex_vld_d, ex_ld_q, ex_ld_d;
  logic [4:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic       ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
  logic       mem_vld_q, mem_ld_q;
  logic [4:0] mem_rd_q;
  logic       wb_vld_q, wb_ld_q;
  logic [4:0] wb_rd_q;

  logic             lu;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Funct fields and immediates are irrelevant to hazards; MEM/WB load flags are kept for visibility only.
  logic unused_bits;
  assign unused_bits = ^{INST_ID[31:25], INST_ID[14:12], mem_ld_q, wb_ld_q};

  // Decode register usage of the instruction sitting in ID
  always_comb begin
    id_op       = INST_ID[6:0];
    id_rs1      = INST_ID[19:15];
    id_rs2      = INST_ID[24:20];
    id_rd       = INST_ID[11:7];
    id_rs1_used = !(id_op inside {OP_LUI, OP_AUIPC, OP_JAL});
    id_rs2_used = id_op inside {OP_R, OP_S, OP_B};
    id_wr       = !(id_op inside {OP_S, OP_B, OP_FENCE, OP_SYSTEM}) && (id_rd != 5'd0);
    id_ld       = (id_op == OP_LOAD);
  end

  // Hazard detection and pipeline control; a taken branch overrides a load-use stall
  always_comb begin
    lu = ex_vld_q && ex_ld_q && (ex_rd_q != 5'd0) &&
         ((id_rs1_used && (id_rs1 == ex_rd_q)) || (id_rs2_used && (id_rs2 == ex_rd_q)));
    PC_en       = 1'b1;
    IF_ID_en    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    if (!rst) begin
      if (PCSel_EX) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (lu) begin
        PC_en       = 1'b0;
        IF_ID_en    = 1'b0;
        ID_EX_flush = 1'b1;
      end
    end
  end

  // EX operand forwarding: the younger MEM result wins over WB
  always_comb begin
    FwdA = 2'b00;
    FwdB = 2'b00;
    if (!rst) begin
      if (ex_rs1_used_q && mem_vld_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs1_q))
        FwdA = 2'b01;
      else if (ex_rs1_used_q && wb_vld_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs1_q))
        FwdA = 2'b10;
      if (ex_rs2_used_q && mem_vld_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs2_q))
        FwdB = 2'b01;
      else if (ex_rs2_used_q && wb_vld_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs2_q))
        FwdB = 2'b10;
    end
  end

  // Next EX entry: ID decode, or an empty bubble when ID/EX is flushed
  always_comb begin
    ex_vld_d      = 1'b1;
    ex_rd_d       = id_wr ? id_rd : 5'd0;
    ex_ld_d       = id_ld;
    ex_rs1_d      = id_rs1;
    ex_rs2_d      = id_rs2;
    ex_rs1_used_d = id_rs1_used;
    ex_rs2_used_d = id_rs2_used;
    if (ID_EX_flush) begin
      ex_vld_d      = 1'b0;
      ex_rd_d       = 5'd0;
      ex_ld_d       = 1'b0;
      ex_rs1_used_d = 1'b0;
      ex_rs2_used_d = 1'b0;
    end
  end

  // Saturating performance counters; a stall pre-empted by a branch is not counted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu && !PCSel_EX && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (PCSel_EX && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // Advance the scoreboard one stage per cycle and update counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_vld_q      <= 1'b0;
      ex_rd_q       <= 5'd0;
      ex_ld_q       <= 1'b0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      mem_vld_q     <= 1'b0;
      mem_rd_q      <= 5'd0;
      mem_ld_q      <= 1'b0;
      wb_vld_q      <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_ld_q       <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      ex_vld_q      <= ex_vld_d;
      ex_rd_q       <= ex_rd_d;
      ex_ld_q       <= ex_ld_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rs1_used_q <= ex_rs1_used_d;
      ex_rs2_used_q <= ex_rs2_used_d;
      mem_vld_q     <= ex_vld_q;
      mem_rd_q      <= ex_rd_q;
      mem_ld_q      <= ex_ld_q;
      wb_vld_q      <= mem_vld_q;
      wb_rd_q       <= mem_rd_q;
      wb_ld_q       <= mem_ld_q;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed RV32I sequences plus randomized traffic.
// Expected outputs come from an instruction-history model and are checked one per cycle.
// Checking runs in a separate monitor that pops the expectation queue on the falling edge.
module tb_hazard_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      INST_ID;
  logic             PCSel_EX;
  logic             PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush;
  logic [1:0]       FwdA, FwdB;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .INST_ID(INST_ID), .PCSel_EX(PCSel_EX),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .FwdA(FwdA), .FwdB(FwdB), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // One instruction as seen by the hazard logic
  typedef struct {
    bit       vld;
    bit [4:0] rd;    // 0 when the instruction does not write a register
    bit       ld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } ins_t;

  typedef struct {
    bit       pc_en;
    bit       ifid_en;
    bit       ifid_fl;
    bit       idex_fl;
    bit [1:0] fa;
    bit [1:0] fb;
    int       scnt;
    int       fcnt;
  } exp_t;

  exp_t expq[$];
  ins_t hist[$];      // hist[0] = EX, hist[1] = MEM, hist[2] = WB
  int   m_scnt, m_fcnt;
  int   checks = 0;
  int   errors = 0;
  bit   last_stall;

  function automatic ins_t bubble();
    ins_t b;
    b.vld = 0; b.rd = 0; b.ld = 0; b.rs1 = 0; b.rs2 = 0; b.u1 = 0; b.u2 = 0;
    return b;
  endfunction

  function automatic ins_t decode(bit [31:0] i);
    ins_t e;
    bit [6:0] op;
    bit wr;
    op    = i[6:0];
    e.vld = 1;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.u1  = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    e.u2  = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    wr    = !(op == 7'b0100011 || op == 7'b1100011 || op == 7'b0001111 || op == 7'b1110011);
    e.rd  = wr ? i[11:7] : 5'd0;
    e.ld  = (op == 7'b0000011);
    return e;
  endfunction

  // Which older in-flight instruction supplies register rs, newest first
  function automatic bit [1:0] fwd_src(bit used, bit [4:0] rs);
    if (!used || rs == 0) return 2'b00;
    if (hist[1].vld && hist[1].rd == rs) return 2'b01;
    if (hist[2].vld && hist[2].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit [31:0] enc_r(bit [6:0] f7, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic bit [31:0] enc_lw(bit [4:0] rd, bit [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic bit [31:0] enc_sw(bit [4:0] rs2, bit [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic bit [31:0] enc_beq(bit [4:0] rs1, bit [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic bit [31:0] enc_lui(bit [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  // Drive one cycle, record what the DUT must show, then advance the model across the edge
  task automatic step(bit [31:0] inst, bit pcsel, bit r);
    exp_t e;
    ins_t d, ex;
    bit   lu;
    @(posedge clk);
    #1;
    INST_ID  = inst;
    PCSel_EX = pcsel;
    rst      = r;
    e.scnt   = m_scnt;
    e.fcnt   = m_fcnt;
    if (r) begin
      e.pc_en = 1; e.ifid_en = 1; e.ifid_fl = 0; e.idex_fl = 0; e.fa = 0; e.fb = 0;
      expq.push_back(e);
      hist = '{bubble(), bubble(), bubble()};
      m_scnt = 0;
      m_fcnt = 0;
      last_stall = 0;
      return;
    end
    d  = decode(inst);
    ex = hist[0];
    lu = ex.vld && ex.ld && ex.rd != 0 &&
         ((d.u1 && d.rs1 == ex.rd) || (d.u2 && d.rs2 == ex.rd));
    e.pc_en   = pcsel || !lu;
    e.ifid_en = pcsel || !lu;
    e.ifid_fl = pcsel;
    e.idex_fl = pcsel || lu;
    e.fa      = fwd_src(ex.u1, ex.rs1);
    e.fb      = fwd_src(ex.u2, ex.rs2);
    expq.push_back(e);
    hist.push_front((pcsel || lu) ? bubble() : d);
    void'(hist.pop_back());
    if (lu && !pcsel && m_scnt < CMAX) m_scnt++;
    if (pcsel && m_fcnt < CMAX) m_fcnt++;
    last_stall = lu && !pcsel;
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Monitor: compare every DUT output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("PC_en",       32'(PC_en),       32'(e.pc_en));
        chk("IF_ID_en",    32'(IF_ID_en),    32'(e.ifid_en));
        chk("IF_ID_flush", 32'(IF_ID_flush), 32'(e.ifid_fl));
        chk("ID_EX_flush", 32'(ID_EX_flush), 32'(e.idex_fl));
        chk("FwdA",        32'(FwdA),        32'(e.fa));
        chk("FwdB",        32'(FwdB),        32'(e.fb));
        chk("stall_cnt",   32'(stall_cnt),   32'(e.scnt));
        chk("flush_cnt",   32'(flush_cnt),   32'(e.fcnt));
      end
    end
  end

  bit [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0100011,
                         7'b1100011, 7'b0001111, 7'b1110011, 7'b0000011, 7'b0010011};

  initial begin
    bit [31:0] inst;
    rst = 1'b1; INST_ID = NOP; PCSel_EX = 1'b0;
    hist = '{bubble(), bubble(), bubble()};
    m_scnt = 0; m_fcnt = 0; last_stall = 0;
    repeat (2) @(posedge clk);

    // reset state
    step(NOP, 0, 1);
    // lw x5 then add x6,x5,x2: one stall, then WB forward
    step(enc_lw(5, 1), 0, 0);
    step(enc_r(7'd0, 6, 5, 2), 0, 0);
    step(enc_r(7'd0, 6, 5, 2), 0, 0);
    step(NOP, 0, 0);
    step(NOP, 0, 0);
    // add x3; add x3,x3,x3; sub x4,x3,x3: MEM beats WB
    step(enc_r(7'd0, 3, 1, 2), 0, 0);
    step(enc_r(7'd0, 3, 3, 3), 0, 0);
    step(enc_r(7'b0100000, 4, 3, 3), 0, 0);
    step(NOP, 0, 0);
    step(NOP, 0, 0);
    // lw x0 then add x6,x0,x0: no stall, no forward
    step(enc_lw(0, 1), 0, 0);
    step(enc_r(7'd0, 6, 0, 0), 0, 0);
    step(NOP, 0, 0);
    step(NOP, 0, 0);
    // branch coincides with a load-use consumer: branch wins
    step(NOP, 0, 1);
    step(enc_lw(5, 1), 0, 0);
    step(enc_r(7'd0, 6, 5, 2), 1, 0);
    step(NOP, 0, 0);
    step(NOP, 0, 0);
    // store data, branch and lui behind a load of x5
    step(enc_lw(5, 1), 0, 0);
    step(enc_sw(5, 1), 0, 0);
    step(enc_sw(5, 1), 0, 0);
    step(enc_lw(5, 1), 0, 0);
    step(enc_beq(0, 0), 0, 0);
    step(enc_lw(5, 1), 0, 0);
    step(enc_lui(5), 0, 0);
    step(NOP, 0, 0);
    // reset with a load in EX clears the scoreboard
    step(enc_lw(5, 1), 0, 0);
    step(enc_r(7'd0, 6, 5, 5), 0, 1);
    step(enc_r(7'd0, 6, 5, 5), 0, 0);
    step(NOP, 0, 0);
    // 20 back-to-back flushes saturate flush_cnt at 15
    repeat (20) step(NOP, 1, 0);
    step(NOP, 0, 0);

    // randomized traffic with small register indices to provoke hazards
    inst = NOP;
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        inst        = $urandom;
        inst[6:0]   = ops[$urandom_range(0, 9)];
        inst[11:7]  = 5'($urandom_range(0, 3));
        inst[19:15] = 5'($urandom_range(0, 3));
        inst[24:20] = 5'($urandom_range(0, 3));
      end
      step(inst, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
    end
    step(NOP, 0, 0);

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
